// File: rtl/l2cache_dv_ctrl.sv
// Dirty/valid SRAM controller for the L2 cache: power-on / on-demand invalidate
// sweep, plus round-robin arbitration between one-way updates and full-set lookups.
module l2cache_dv_ctrl #(
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic [6:0]  rd_set,
  output logic        rd_gnt,
  output logic        rd_vld,
  output logic [15:0] rd_data,
  input  logic        wr_req,
  input  logic [9:0]  wr_addr,
  input  logic [1:0]  wr_data,
  output logic        wr_gnt,
  input  logic        inv_req,
  output logic        init_busy,
  output logic        sram_we,
  output logic [9:0]  sram_addr,
  output logic [1:0]  sram_din,
  input  logic [15:0] sram_dout
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        wr_wins_q, wr_wins_d;   // 1: write takes the next contested cycle
  logic [9:0]  addr_q;
  logic        rd_vld_p1;

  logic        rd_gnt_c, wr_gnt_c, we_c;
  logic [9:0]  addr_c;
  logic [1:0]  din_c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_wins_d = wr_wins_q;
    rd_gnt_c  = 1'b0;
    wr_gnt_c  = 1'b0;
    we_c      = 1'b0;
    addr_c    = addr_q;
    din_c     = 2'b00;
    case (state_q)
      ST_INIT: begin
        we_c   = 1'b1;
        addr_c = cnt_q;
        cnt_d  = cnt_q + 10'd1;
        if (cnt_q == 10'd1023) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (inv_req) begin
          state_d = ST_INIT;
        end else begin
          if (wr_req && rd_req) begin
            wr_gnt_c  = wr_wins_q;
            rd_gnt_c  = !wr_wins_q;
            wr_wins_d = !wr_wins_q;
          end else begin
            wr_gnt_c = wr_req;
            rd_gnt_c = rd_req;
          end
          if (wr_gnt_c) begin
            we_c   = 1'b1;
            addr_c = wr_addr;
            din_c  = wr_data;
          end else if (rd_gnt_c) begin
            addr_c = {rd_set, 3'b000};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      cnt_q     <= 10'd0;
      wr_wins_q <= 1'b1;
      addr_q    <= 10'd0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_wins_q <= wr_wins_d;
      addr_q    <= addr_c;
      // p0 -> p1: SRAM read latency, data returns with rd_vld_p1
      rd_vld_p1 <= rd_gnt_c;
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign rd_gnt    = rst_n & rd_gnt_c;
  assign wr_gnt    = rst_n & wr_gnt_c;
  assign sram_we   = rst_n & we_c;
  assign sram_addr = rst_n ? addr_c : 10'd0;
  assign sram_din  = rst_n ? din_c : 2'b00;
  assign rd_vld    = rd_vld_p1;
  assign rd_data   = rd_vld_p1 ? sram_dout : 16'd0;
  assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_l2cache_dv_ctrl.sv
// Randomized scoreboard bench for l2cache_dv_ctrl with a way-level reference
// memory, an SRAM model, and a monitor that retires expected lookup results.
module tb_l2cache_dv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req, wr_req, inv_req;
  logic [6:0]  rd_set;
  logic [9:0]  wr_addr;
  logic [1:0]  wr_data;
  logic        rd_gnt, rd_vld, wr_gnt, init_busy, sram_we;
  logic [15:0] rd_data, sram_dout;
  logic [9:0]  sram_addr;
  logic [1:0]  sram_din;

  l2cache_dv_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_set(rd_set), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .inv_req(inv_req), .init_busy(init_busy),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // SRAM model: one 16-bit row per set, 2-bit write lanes, one-cycle read latency.
  logic [15:0] mem [128];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= 16'($urandom);
    end else begin
      if (sram_we) mem[sram_addr[9:3]][{sram_addr[2:0], 1'b0} +: 2] <= sram_din;
      sram_dout <= mem[sram_addr[9:3]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: dirty/valid per (set, way), and the contest winner rule.
  logic [1:0] ref_mem [128][8];
  logic       model_wr_next;
  logic [9:0] last_addr;

  typedef struct { int cyc; logic [15:0] data; } exp_t;
  exp_t sb [$];

  function automatic logic [15:0] ref_row(input logic [6:0] s);
    logic [15:0] r;
    for (int w = 0; w < 8; w++) r[w*2 +: 2] = ref_mem[s][w];
    return r;
  endfunction

  task automatic clear_ref();
    for (int s = 0; s < 128; s++)
      for (int w = 0; w < 8; w++) ref_mem[s][w] = 2'b00;
  endtask

  logic mon_exp;
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("rd_vld_missed_cycle", 64'(sb[0].cyc), 64'(cyc));
        void'(sb.pop_front());
      end
      mon_exp = (sb.size() > 0) && (sb[0].cyc == cyc);
      check("rd_vld", rd_vld, mon_exp);
      if (mon_exp) begin
        check("rd_data", rd_data, sb[0].data);
        void'(sb.pop_front());
      end
    end
  end

  // One RUN cycle: drive at posedge+1, check grants and SRAM port at negedge.
  task automatic step(input logic r, input logic [6:0] s, input logic w,
                      input logic [9:0] a, input logic [1:0] d, input logic inv,
                      output logic gr, output logic gw);
    logic ew, er;
    rd_req = r; rd_set = s; wr_req = w; wr_addr = a; wr_data = d; inv_req = inv;
    @(negedge clk);
    ew = w && !inv && (!r || model_wr_next);
    er = r && !inv && (!w || !model_wr_next);
    check("grants", {rd_gnt, wr_gnt}, {er, ew});
    check("busy_in_run", init_busy, 1'b0);
    if (ew) begin
      check("wr_port", {sram_we, sram_addr, sram_din}, {1'b1, a, d});
      ref_mem[a[9:3]][a[2:0]] = d;
      last_addr = a;
    end else if (er) begin
      check("rd_port", {sram_we, sram_addr}, {1'b0, s, 3'b000});
      sb.push_back('{cyc: cyc + 1, data: ref_row(s)});
      last_addr = {s, 3'b000};
    end else begin
      check("idle_port", {sram_we, sram_addr}, {1'b0, last_addr});
    end
    if (r && w && !inv) model_wr_next = !model_wr_next;
    gr = rd_gnt;
    gw = wr_gnt;
    @(posedge clk); #1;
  endtask

  // Checks n sweep cycles starting with the next negedge; returns at posedge+1.
  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("sweep", {init_busy, sram_we, sram_addr, sram_din, rd_gnt, wr_gnt},
            {1'b1, 1'b1, 10'(i), 2'b00, 1'b0, 1'b0});
      last_addr = 10'(i);
      @(posedge clk); #1;
      inv_req = (i < n - 1) ? ($urandom_range(0, 15) == 0) : 1'b0;
    end
    if (n == 1024) clear_ref();
  endtask

  task automatic chk_rst();
    check("reset_outputs",
          {rd_gnt, wr_gnt, rd_vld, rd_data, sram_we, sram_addr, sram_din, init_busy}, 64'd1);
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    sb.delete();
    model_wr_next = 1'b1;
    last_addr = 10'd0;
  endtask

  logic       gr, gw, pr, pw;
  logic [6:0] s;
  logic [9:0] a;
  logic [1:0] d;

  initial begin
    enter_reset();
    rd_req = 1'b1; wr_req = 1'b1; inv_req = 1'b1;
    rd_set = 7'h11; wr_addr = 10'h155; wr_data = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst();
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0; inv_req = 1'b0;
    rst_n = 1'b1;
    sweep(1024);

    // Write then read of the same set on the next cycle.
    step(1'b0, 7'h0, 1'b1, 10'h2A3, 2'b11, 1'b0, gr, gw);
    step(1'b1, 7'h54, 1'b0, 10'h0, 2'b00, 1'b0, gr, gw);
    step(1'b0, 7'h0, 1'b0, 10'h0, 2'b00, 1'b0, gr, gw);

    // Both requesters held for six cycles: W,R,W,R,W,R from a fresh pointer.
    for (int k = 0; k < 6; k++)
      step(1'b1, 7'h54, 1'b1, {7'h54, 3'(k)}, 2'(k), 1'b0, gr, gw);
    step(1'b0, 7'h0, 1'b0, 10'h0, 2'b00, 1'b0, gr, gw);

    // Random traffic with hold-until-grant requesters.
    pr = 1'b0; pw = 1'b0; s = 7'h0; a = 10'h0; d = 2'b00;
    for (int k = 0; k < 400; k++) begin
      if (!pr && $urandom_range(0, 1) == 1) begin pr = 1'b1; s = 7'($urandom_range(80, 83)); end
      if (!pw && $urandom_range(0, 1) == 1) begin
        pw = 1'b1;
        a  = {7'($urandom_range(80, 83)), 3'($urandom_range(0, 7))};
        d  = 2'($urandom_range(0, 3));
      end
      step(pr, s, pw, a, d, 1'b0, gr, gw);
      if (gr) pr = 1'b0;
      if (gw) pw = 1'b0;
    end
    for (int k = 0; k < 4 && (pr || pw); k++) begin
      step(pr, s, pw, a, d, 1'b0, gr, gw);
      if (gr) pr = 1'b0;
      if (gw) pw = 1'b0;
    end
    check("random_drain", {pr, pw}, 2'b00);

    // Invalidate with a write pending, right after a granted read.
    step(1'b1, 7'h52, 1'b0, 10'h0, 2'b00, 1'b0, gr, gw);
    step(1'b0, 7'h0, 1'b1, 10'h293, 2'b01, 1'b1, gr, gw);
    sweep(1024);
    step(1'b0, 7'h0, 1'b1, 10'h293, 2'b01, 1'b0, gr, gw);
    step(1'b1, 7'h52, 1'b0, 10'h0, 2'b00, 1'b0, gr, gw);
    step(1'b0, 7'h0, 1'b0, 10'h0, 2'b00, 1'b0, gr, gw);

    // Reset while a lookup is in flight, then reset again mid-sweep.
    step(1'b1, 7'h52, 1'b0, 10'h0, 2'b00, 1'b0, gr, gw);
    #2 enter_reset();
    #1 chk_rst();
    @(posedge clk); #1 rst_n = 1'b1;
    sweep(500);
    #2 enter_reset();
    #1 chk_rst();
    @(posedge clk); #1 rst_n = 1'b1;
    sweep(1024);
    step(1'b1, 7'h52, 1'b1, 10'h290, 2'b10, 1'b0, gr, gw);
    step(1'b1, 7'h52, 1'b0, 10'h0, 2'b00, 1'b0, gr, gw);
    step(1'b0, 7'h0, 1'b0, 10'h0, 2'b00, 1'b0, gr, gw);
    step(1'b0, 7'h0, 1'b0, 10'h0, 2'b00, 1'b0, gr, gw);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/l2cache_dv_ctrl.md
L2CACHE_DV_CTRL -- requirements
Module: l2cache_dv_ctrl

Interface
REQ-001 Parameter INIT_ON_RESET, default 1, meaning: 1 = start the invalidate sweep automatically on reset release; 0 = start in RUN.
REQ-002 clk  input  1  single clock for all state and for the dirty/valid SRAM.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 rd_req  input  1  lookup requester wants all 8 ways of one set.
REQ-005 rd_set  input  7  set index for the lookup.
REQ-006 rd_gnt  output  1  lookup accepted this cycle.
REQ-007 rd_vld  output  1  lookup data valid.
REQ-008 rd_data  output  16  {way7..way0} 2-bit dirty/valid fields.
REQ-009 wr_req  input  1  update requester wants to write one way.
REQ-010 wr_addr  input  10  [9:3] set, [2:0] way.
REQ-011 wr_data  input  2  new {dirty,valid} value.
REQ-012 wr_gnt  output  1  update accepted this cycle.
REQ-013 inv_req  input  1  request a full invalidate sweep.
REQ-014 init_busy  output  1  sweep in progress.
REQ-015 sram_we  output  1  SRAM write enable, active-high.
REQ-016 sram_addr  output  10  SRAM address.
REQ-017 sram_din  output  2  SRAM write data.
REQ-018 sram_dout  input  16  SRAM read data, valid the cycle after the read address is presented.

Function
REQ-019 FSM states: INIT and RUN.
REQ-020 On reset, the FSM enters INIT when INIT_ON_RESET=1, else RUN.
REQ-021 INIT: a 10-bit counter starts at 0; each cycle drives sram_we=1, sram_addr=counter, sram_din=2'b00; counter increments.
REQ-022 INIT exits to RUN after the write at address 1023; the sweep takes exactly 1024 cycles; the counter returns to 0.
REQ-023 init_busy is 1 in INIT and 0 in RUN.
REQ-024 rd_gnt and wr_gnt are 0 in every INIT cycle.
REQ-025 RUN, arbitration:
- only wr_req set -> grant the write;
- only rd_req set -> grant the read;
- both set -> grant the class not granted in the most recent contested cycle;
- on the first contested cycle after reset, the write wins.
REQ-026 Grants are combinational from the requests in the same cycle; a requester holds its req and operands until it sees its gnt.
REQ-027 Granted write: sram_we=1, sram_addr=wr_addr, sram_din=wr_data.
REQ-028 Granted read: sram_we=0, sram_addr={rd_set,3'b000}.
REQ-029 No grant: sram_we=0 and sram_addr holds its previous value.
REQ-030 rd_vld is 1 exactly one cycle after rd_gnt, with rd_data=sram_dout; rd_vld does not depend on FSM state.
REQ-031 A write granted in cycle N is visible to a read granted in cycle N+1 or later; no bypass logic exists.
REQ-032 inv_req is sampled only in RUN. When asserted, that cycle's grants are suppressed and the FSM enters INIT on the next edge. A read granted in the previous cycle still returns rd_vld.
REQ-033 inv_req during INIT is ignored; the sweep is not restarted.

Reset
REQ-034 While rst_n=0, all outputs are 0: rd_gnt, wr_gnt, rd_vld, rd_data, sram_we, sram_addr, sram_din.
REQ-035 Also while rst_n=0: init_busy=INIT_ON_RESET, counter=0, and the round-robin pointer selects write.
REQ-036 Reset asserted mid-sweep or mid-read aborts immediately; no rd_vld follows reset.

Verification
REQ-037 Reset release, INIT_ON_RESET=1 -> init_busy=1 for exactly 1024 cycles; sram_we=1 with addresses 0..1023 in order and sram_din=0; then init_busy=0.
REQ-038 RUN, write addr=10'h2A3 data=2'b11, then read set 7'h54 next cycle -> rd_vld one cycle after rd_gnt; rd_data[7:6]=2'b11.
REQ-039 RUN, rd_req and wr_req held high for 6 cycles -> grants go W,R,W,R,W,R; rd_vld follows each rd_gnt by one cycle.
REQ-040 rd_req only -> rd_gnt the same cycle; sram_addr={set,000}; sram_we=0.
REQ-041 inv_req pulse in the same cycle as a pending wr_req -> no wr_gnt; the 1024-cycle sweep follows; the write is granted on the first RUN cycle afterward.
REQ-042 rst_n dropped at sweep address 500 -> outputs reset asynchronously; on release, the sweep restarts at address 0.
